// File: rtl/weight_ram_if.sv
// -----------------------------------------------------------------------------
// weight_ram_if
//   Bundles the two ways into a weight_ram: the layer-side RAM port
//   (enable, ram_write, ram_addr_*, ram_data_*) and the host streaming load
//   port (load_start/load_addr/load_valid/load_data, load_ready/load_wrap).
//
//   master : the layer + host loader side (drives addresses, data, strobes)
//   slave  : the memory (drives ram_data_read, load_ready, load_wrap)
// -----------------------------------------------------------------------------
interface weight_ram_if #(
  parameter int NUM_W      = 16,
  parameter int RAM_ADDR_W = 8
);
  // Layer port
  logic                  enable;
  logic                  ram_write;
  logic [RAM_ADDR_W-1:0] ram_addr_write;
  logic [NUM_W-1:0]      ram_data_write;
  logic [RAM_ADDR_W-1:0] ram_addr_read;
  logic [NUM_W-1:0]      ram_data_read;

  // Host load stream
  logic                  load_start;
  logic [RAM_ADDR_W-1:0] load_addr;
  logic                  load_valid;
  logic [NUM_W-1:0]      load_data;
  logic                  load_ready;
  logic                  load_wrap;

  modport master (
    output enable, ram_write, ram_addr_write, ram_data_write, ram_addr_read,
    output load_start, load_addr, load_valid, load_data,
    input  ram_data_read, load_ready, load_wrap
  );

  modport slave (
    input  enable, ram_write, ram_addr_write, ram_data_write, ram_addr_read,
    input  load_start, load_addr, load_valid, load_data,
    output ram_data_read, load_ready, load_wrap
  );
endinterface

// File: rtl/weight_ram.sv
// -----------------------------------------------------------------------------
// weight_ram
//   Per-layer weight/bias memory. The layer reads through a fixed-latency
//   pipeline (RAM_DELAY enabled cycles) and may write single words; the host
//   fills the memory through a valid/ready stream with an auto-incrementing
//   pointer.
//
//   clk     : clock, all state on the rising edge
//   nreset  : asynchronous active-low reset (clears pipeline, pointer, wrap;
//             memory contents are kept)
//   bus     : weight_ram_if.slave
//             enable         - advances read pipeline, gates layer writes
//             ram_write      - layer write strobe
//             ram_addr_write - layer write address
//             ram_data_write - layer write data
//             ram_addr_read  - layer read address, sampled every enabled cycle
//             ram_data_read  - read data, RAM_DELAY enabled cycles later
//             load_start     - pulse, pointer <= load_addr
//             load_addr      - start address of the load stream
//             load_valid     - load beat valid
//             load_data      - load beat data
//             load_ready     - beat accepted when load_valid && load_ready
//             load_wrap      - one-cycle pulse after a beat written at DEPTH-1
// -----------------------------------------------------------------------------
module weight_ram #(
  parameter int NUM_W      = 16,
  parameter int RAM_ADDR_W = 8,
  parameter int DEPTH      = 256,
  parameter int RAM_DELAY  = 3
) (
  input  logic        clk,
  input  logic        nreset,
  weight_ram_if.slave bus
);

  // One extra bit so DEPTH == 2**RAM_ADDR_W is representable.
  localparam logic [RAM_ADDR_W:0]   DEPTH_X   = (RAM_ADDR_W+1)'(DEPTH);
  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(DEPTH - 1);

  logic [NUM_W-1:0]      mem_q  [DEPTH];
  logic [NUM_W-1:0]      pipe_q [RAM_DELAY];
  logic [NUM_W-1:0]      rd_word_d;
  logic [RAM_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  wrap_q, wrap_d;

  logic rd_in_range, wr_in_range, ptr_in_range;
  logic layer_wr, layer_we, load_ready, load_accept, load_we;

  assign rd_in_range  = {1'b0, bus.ram_addr_read}  < DEPTH_X;
  assign wr_in_range  = {1'b0, bus.ram_addr_write} < DEPTH_X;
  assign ptr_in_range = {1'b0, ptr_q}              < DEPTH_X;

  // An out-of-range layer write still claims the cycle, so the loader stalls
  // on layer_wr rather than on the qualified write enable.
  assign layer_wr    = bus.enable && bus.ram_write;
  assign layer_we    = layer_wr && wr_in_range;
  assign load_ready  = !bus.load_start && !layer_wr;
  assign load_accept = bus.load_valid && load_ready;
  assign load_we     = load_accept && ptr_in_range;

  // ---------------------------------------------------------------------------
  // Storage. Layer and load writes are mutually exclusive via load_ready.
  // Reads sample mem_q before this edge's write lands: read-before-write.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch on purpose; clearing every word would
  // defeat RAM inference and the contents must survive nreset anyway.
  always_ff @(posedge clk) begin
    if (layer_we) begin
      mem_q[bus.ram_addr_write] <= bus.ram_data_write;
    end else if (load_we) begin
      mem_q[ptr_q] <= bus.load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 is the array read, the rest are pure delay.
  // The whole chain holds while enable is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word_d = rd_in_range ? mem_q[bus.ram_addr_read] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < RAM_DELAY; i++) pipe_q[i] <= '0;
    end else if (bus.enable) begin
      pipe_q[0] <= rd_word_d;
      for (int i = 1; i < RAM_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Load pointer. A bad start address still consumes the beat but only
  // resets the pointer; only a real write at DEPTH-1 produces a wrap pulse.
  // ---------------------------------------------------------------------------
  // NOTE: defaults first so no path through this block leaves ptr_d/wrap_d
  // unassigned, which would otherwise infer latches.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    if (bus.load_start) begin
      ptr_d = bus.load_addr;
    end else if (load_accept) begin
      if (!ptr_in_range) begin
        ptr_d = '0;
      end else if (ptr_q == LAST_ADDR) begin
        ptr_d  = '0;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.ram_data_read = pipe_q[RAM_DELAY-1];
  assign bus.load_ready    = load_ready;
  assign bus.load_wrap     = wrap_q;

endmodule
